// File: rtl/regfile_pkg.sv
// Shared constants and state type for the register-bank burst reader.
// Optional write-through forwarding is enabled by REGFILE_READ_BYPASS_EN.
package regfile_pkg;
   localparam int NUM_REGS = 23;
   localparam int DATA_W   = 64;
   localparam int ADDR_W   = 5;
   localparam int LEN_W    = 5;

   typedef enum logic [1:0] {
      IDLE,
      BURST,
      ERR
   } rd_state_t;
endpackage

// File: rtl/regfile_burst_reader_if.sv
// Request and response channels of the burst reader (valid/ready both ways).
// The requester is the master; the reader is the slave.
interface regfile_burst_reader_if;
   import regfile_pkg::*;

   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] req_addr;
   logic [LEN_W-1:0]  req_len;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_data;
   logic [ADDR_W-1:0] rsp_addr;
   logic              rsp_last;
   logic              rsp_err;

   modport master (
      output req_valid, req_addr, req_len, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_addr, rsp_last, rsp_err
   );

   modport slave (
      input  req_valid, req_addr, req_len, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_addr, rsp_last, rsp_err
   );
endinterface

// File: rtl/regfile_read_mux.sv
// NUM_REGS:1 word selector over the flattened bank; out-of-range index gives 0.
// Under REGFILE_READ_BYPASS_EN a same-cycle write to the selected register wins.
module regfile_read_mux
   import regfile_pkg::*;
(
   input  logic [NUM_REGS*DATA_W-1:0] regs_flat,
   input  logic [ADDR_W-1:0]          idx,
`ifdef REGFILE_READ_BYPASS_EN
   input  logic [NUM_REGS-1:0]        wr_en,
   input  logic [DATA_W-1:0]          wr_data,
`endif
   output logic [DATA_W-1:0]          data
);

   always_comb begin
      data = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (idx == ADDR_W'(i)) begin
`ifdef REGFILE_READ_BYPASS_EN
            data = wr_en[i] ? wr_data : regs_flat[i*DATA_W +: DATA_W];
`else
            data = regs_flat[i*DATA_W +: DATA_W];
`endif
         end
      end
   end

endmodule

// File: rtl/regfile_burst_reader.sv
// Streams a range of bank registers out one beat per cycle with last/err flags.
// Define REGFILE_READ_BYPASS_EN to add wr_en/wr_data write-through forwarding.
module regfile_burst_reader
   import regfile_pkg::*;
(
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_REGS*DATA_W-1:0] regs_flat,
`ifdef REGFILE_READ_BYPASS_EN
   input  logic [NUM_REGS-1:0]        wr_en,
   input  logic [DATA_W-1:0]          wr_data,
`endif
   regfile_burst_reader_if.slave      bus,
   output logic                       busy
);

   rd_state_t         state;
   logic [ADDR_W-1:0] cur_addr;
   logic [LEN_W-1:0]  remain;
   logic [DATA_W-1:0] rd_data;
   logic              cap;

   regfile_read_mux u_mux (
      .regs_flat (regs_flat),
      .idx       (cur_addr),
`ifdef REGFILE_READ_BYPASS_EN
      .wr_en     (wr_en),
      .wr_data   (wr_data),
`endif
      .data      (rd_data)
   );

   assign bus.req_ready = (state == IDLE) && !bus.rsp_valid;
   assign cap           = !bus.rsp_valid || bus.rsp_ready;
   assign busy          = (state != IDLE) || bus.rsp_valid;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         cur_addr      <= '0;
         remain        <= '0;
         bus.rsp_valid <= 1'b0;
         bus.rsp_data  <= '0;
         bus.rsp_addr  <= '0;
         bus.rsp_last  <= 1'b0;
         bus.rsp_err   <= 1'b0;
      end else begin
         // a consumed beat drops valid unless a new beat replaces it below
         if (bus.rsp_valid && bus.rsp_ready)
            bus.rsp_valid <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.req_valid && bus.req_ready) begin
                  cur_addr <= bus.req_addr;
                  remain   <= bus.req_len;
                  state    <= (bus.req_addr < ADDR_W'(NUM_REGS)) ? BURST : ERR;
               end
            end
            BURST: begin
               if (cap) begin
                  bus.rsp_valid <= 1'b1;
                  bus.rsp_data  <= rd_data;
                  bus.rsp_addr  <= cur_addr;
                  bus.rsp_err   <= 1'b0;
                  bus.rsp_last  <= (remain == '0);
                  cur_addr      <= (cur_addr == ADDR_W'(NUM_REGS - 1)) ?
                                   '0 : cur_addr + 1'b1;
                  remain        <= remain - 1'b1;
                  if (remain == '0)
                     state <= IDLE;
               end
            end
            ERR: begin
               if (cap) begin
                  bus.rsp_valid <= 1'b1;
                  bus.rsp_data  <= '0;
                  bus.rsp_addr  <= cur_addr;
                  bus.rsp_err   <= 1'b1;
                  bus.rsp_last  <= 1'b1;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
